// File: rtl/oka_pp_serial_6bit.sv
// oka_pp_serial_6bit
// Bit-serial generator of the four half-by-half carry-less sub-products
// used by the overlap-free Karatsuba recombination stage. Each operand is
// split into even-indexed (Ae/Be) and odd-indexed (Ao/Bo) coefficient
// halves. One shift-and-XOR step per cycle builds all four products in
// parallel over H cycles. Results are held in output registers and
// qualified by out_valid on a valid/ready handshake.

module oka_pp_serial_6bit #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-2:0] pp1,
  output logic [N-2:0] pp2,
  output logic [N-2:0] pp3,
  output logic [N-2:0] pp4
);

  localparam int H  = N / 2;
  localparam int PW = N - 1;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(H - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic            in_ready_s;
  logic            accept_s;
  logic            last_step_s;
  logic            out_valid_r;

  logic [CW-1:0]   cnt_r;
  logic [H-1:0]    ae_r, ao_r, be_r, bo_r;
  logic [H-1:0]    a_even_s, a_odd_s, b_even_s, b_odd_s;
  logic [PW-1:0]   acc1_r, acc2_r, acc3_r, acc4_r;
  logic [PW-1:0]   acc1_next_s, acc2_next_s, acc3_next_s, acc4_next_s;
  logic [PW-1:0]   ae_sh_s, ao_sh_s;
  logic [PW-1:0]   pp1_r, pp2_r, pp3_r, pp4_r;

  // Split the incoming operands into even- and odd-indexed coefficient halves.
  always_comb begin
    a_even_s = {H{1'b0}};
    a_odd_s  = {H{1'b0}};
    b_even_s = {H{1'b0}};
    b_odd_s  = {H{1'b0}};
    for (int j = 0; j < H; j++) begin
      a_even_s[j] = a_in[2*j];
      a_odd_s[j]  = a_in[2*j+1];
      b_even_s[j] = b_in[2*j];
      b_odd_s[j]  = b_in[2*j+1];
    end
  end

  // One shift-and-XOR step: fold the A halves shifted by cnt into each
  // accumulator, gated by the cnt-th coefficient of the matching B half.
  always_comb begin
    ae_sh_s     = PW'(ae_r) << cnt_r;
    ao_sh_s     = PW'(ao_r) << cnt_r;
    acc1_next_s = acc1_r ^ (be_r[cnt_r] ? ae_sh_s : {PW{1'b0}});
    acc2_next_s = acc2_r ^ (bo_r[cnt_r] ? ae_sh_s : {PW{1'b0}});
    acc3_next_s = acc3_r ^ (be_r[cnt_r] ? ao_sh_s : {PW{1'b0}});
    acc4_next_s = acc4_r ^ (bo_r[cnt_r] ? ao_sh_s : {PW{1'b0}});
  end

  // Next-state and handshake decode; in_ready depends only on state and out_ready.
  always_comb begin
    state_next_s = state_r;
    in_ready_s   = 1'b0;
    last_step_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        in_ready_s = 1'b0;
        if (cnt_r == CNT_LAST) begin
          last_step_s  = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        in_ready_s = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            state_next_s = ST_BUSY;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        in_ready_s   = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
    accept_s = in_valid & in_ready_s;
  end

  // State register and registered out_valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s == ST_DONE);
    end
  end

  // Operand capture, accumulation steps and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= CNT_ZERO;
      ae_r   <= {H{1'b0}};
      ao_r   <= {H{1'b0}};
      be_r   <= {H{1'b0}};
      bo_r   <= {H{1'b0}};
      acc1_r <= {PW{1'b0}};
      acc2_r <= {PW{1'b0}};
      acc3_r <= {PW{1'b0}};
      acc4_r <= {PW{1'b0}};
      pp1_r  <= {PW{1'b0}};
      pp2_r  <= {PW{1'b0}};
      pp3_r  <= {PW{1'b0}};
      pp4_r  <= {PW{1'b0}};
    end else if (accept_s) begin
      cnt_r  <= CNT_ZERO;
      ae_r   <= a_even_s;
      ao_r   <= a_odd_s;
      be_r   <= b_even_s;
      bo_r   <= b_odd_s;
      acc1_r <= {PW{1'b0}};
      acc2_r <= {PW{1'b0}};
      acc3_r <= {PW{1'b0}};
      acc4_r <= {PW{1'b0}};
    end else if (state_r == ST_BUSY) begin
      acc1_r <= acc1_next_s;
      acc2_r <= acc2_next_s;
      acc3_r <= acc3_next_s;
      acc4_r <= acc4_next_s;
      if (last_step_s) begin
        // Counter wraps to zero so it never leaves 0..H-1.
        cnt_r <= CNT_ZERO;
        pp1_r <= acc1_next_s;
        pp2_r <= acc2_next_s;
        pp3_r <= acc3_next_s;
        pp4_r <= acc4_next_s;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign pp1       = pp1_r;
  assign pp2       = pp2_r;
  assign pp3       = pp3_r;
  assign pp4       = pp4_r;

endmodule
